// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU op codes, M-unit state encoding.
package exe_pkg;

  localparam logic [4:0] ALUOP_ADD    = 5'd0;
  localparam logic [4:0] ALUOP_SUB    = 5'd1;
  localparam logic [4:0] ALUOP_SLL    = 5'd2;
  localparam logic [4:0] ALUOP_SLT    = 5'd3;
  localparam logic [4:0] ALUOP_SLTU   = 5'd4;
  localparam logic [4:0] ALUOP_XOR    = 5'd5;
  localparam logic [4:0] ALUOP_SRL    = 5'd6;
  localparam logic [4:0] ALUOP_SRA    = 5'd7;
  localparam logic [4:0] ALUOP_OR     = 5'd8;
  localparam logic [4:0] ALUOP_AND    = 5'd9;
  localparam logic [4:0] ALUOP_PASSB  = 5'd10;
  localparam logic [4:0] ALUOP_MUL    = 5'd16;
  localparam logic [4:0] ALUOP_MULH   = 5'd17;
  localparam logic [4:0] ALUOP_MULHSU = 5'd18;
  localparam logic [4:0] ALUOP_MULHU  = 5'd19;
  localparam logic [4:0] ALUOP_DIV    = 5'd20;
  localparam logic [4:0] ALUOP_DIVU   = 5'd21;
  localparam logic [4:0] ALUOP_REM    = 5'd22;
  localparam logic [4:0] ALUOP_REMU   = 5'd23;

  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_DONE} md_state_t;

  function automatic logic is_mdu(input logic [4:0] op);
    return op[4];
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiply/divide: shift-add multiply, restoring divide,
// magnitudes in, sign fixed up in DONE. Division corner cases bypass CALC.
module muldiv_iter
  import exe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MD_ITER = 32
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(MD_ITER);

  md_state_t         state, state_n;
  logic [CW-1:0]     cnt;
  logic [4:0]        op_q;
  logic              neg_q;
  logic [2*XLEN-1:0] p, p_step, prod;
  logic [XLEN-1:0]   m, a_mag, b_mag, quo, rem;
  logic              a_sgn, b_sgn, neg, special;
  logic [XLEN:0]     sh, add;
  logic [XLEN+1:0]   diff;

  // Operand conditioning at start time
  always_comb begin
    a_sgn   = (op == ALUOP_MULH || op == ALUOP_MULHSU || op == ALUOP_DIV || op == ALUOP_REM) && a[XLEN-1];
    b_sgn   = (op == ALUOP_MULH || op == ALUOP_DIV || op == ALUOP_REM) && b[XLEN-1];
    a_mag   = a_sgn ? -a : a;
    b_mag   = b_sgn ? -b : b;
    neg     = (op == ALUOP_REM) ? a_sgn : ((op == ALUOP_DIVU || op == ALUOP_REMU) ? 1'b0 : a_sgn ^ b_sgn);
    special = op[2] && ((b == '0) ||
              ((op == ALUOP_DIV || op == ALUOP_REM) && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1));
  end

  // One iteration step; p holds {rem, quo} for divide, {hi, lo/multiplier} for multiply
  always_comb begin
    sh   = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    diff = {1'b0, sh} - {2'b0, m};
    add  = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
    if (op_q[2])
      p_step = diff[XLEN+1] ? {sh[XLEN-1:0], p[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0], p[XLEN-2:0], 1'b1};
    else
      p_step = {add, p[XLEN-1:1]};
  end

  always_comb begin
    state_n = state;
    case (state)
      MD_IDLE: if (start) state_n = special ? MD_DONE : MD_CALC;
      MD_CALC: if (cnt == CW'(MD_ITER-1)) state_n = MD_DONE;
      MD_DONE: state_n = MD_IDLE;
      default: state_n = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= MD_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      p     <= '0;
      m     <= '0;
    end else begin
      state <= state_n;
      if (state == MD_IDLE && start) begin
        op_q <= op;
        cnt  <= '0;
        if (special) begin
          // Preload {rem, quo} so DONE needs no separate special-result path
          neg_q <= 1'b0;
          p     <= (b == '0) ? {a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
        end else begin
          neg_q <= neg;
          p     <= op[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
          m     <= op[2] ? b_mag : a_mag;
        end
      end else if (state == MD_CALC) begin
        cnt <= cnt + CW'(1);
        p   <= p_step;
      end
    end
  end

  always_comb begin
    prod = neg_q ? -p : p;
    quo  = neg_q ? -p[XLEN-1:0] : p[XLEN-1:0];
    rem  = neg_q ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    if (op_q[2])      result = op_q[1] ? rem : quo;
    else if (op_q == ALUOP_MUL) result = prod[XLEN-1:0];
    else              result = prod[2*XLEN-1:XLEN];
  end

  assign busy = (state == MD_IDLE && start) || state == MD_CALC;
  assign done = (state == MD_DONE);

endmodule

// File: rtl/exe_stage.sv
// RV32IM execute stage: single-cycle ALU, iterative M-unit, EX/MEM register.
module exe_stage
  import exe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MD_ITER = 32
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            IdEx_Valid,
  input  logic [4:0]      IdEx_AluOp,
  input  logic [XLEN-1:0] IdEx_OpA,
  input  logic [XLEN-1:0] IdEx_OpB,
  input  logic [XLEN-1:0] IdEx_Rs2Data,
  input  logic [XLEN-1:0] IdEx_Pc4,
  input  logic            IdEx_Jump,
  input  logic            IdEx_MemToReg,
  input  logic            IdEx_MemRead,
  input  logic            IdEx_MemWrite,
  input  logic [4:0]      IdEx_RegRd,
  input  logic            IdEx_RegWrite,
  output logic            ExStall,
  output logic [XLEN-1:0] ExMem_AluResult,
  output logic [XLEN-1:0] ExMem_AluB_Pc4,
  output logic            ExMem_MemToReg,
  output logic            ExMem_MemRead,
  output logic            ExMem_MemWrite,
  output logic [4:0]      ExMem_RegRd,
  output logic            ExMem_RegWrite
);
  logic [XLEN-1:0] alu, md_result;
  logic [4:0]      shamt;
  logic            md_busy, md_done;

  muldiv_iter #(.XLEN(XLEN), .MD_ITER(MD_ITER)) u_md (
    .clk    (clk),
    .rstb   (rstb),
    .start  (IdEx_Valid && is_mdu(IdEx_AluOp)),
    .op     (IdEx_AluOp),
    .a      (IdEx_OpA),
    .b      (IdEx_OpB),
    .busy   (md_busy),
    .done   (md_done),
    .result (md_result)
  );

  assign ExStall = md_busy;
  assign shamt   = IdEx_OpB[4:0];

  always_comb begin
    alu = '0;
    case (IdEx_AluOp)
      ALUOP_ADD:   alu = IdEx_OpA + IdEx_OpB;
      ALUOP_SUB:   alu = IdEx_OpA - IdEx_OpB;
      ALUOP_SLL:   alu = IdEx_OpA << shamt;
      ALUOP_SLT:   alu = {{(XLEN-1){1'b0}}, $signed(IdEx_OpA) < $signed(IdEx_OpB)};
      ALUOP_SLTU:  alu = {{(XLEN-1){1'b0}}, IdEx_OpA < IdEx_OpB};
      ALUOP_XOR:   alu = IdEx_OpA ^ IdEx_OpB;
      ALUOP_SRL:   alu = IdEx_OpA >> shamt;
      ALUOP_SRA:   alu = $unsigned($signed(IdEx_OpA) >>> shamt);
      ALUOP_OR:    alu = IdEx_OpA | IdEx_OpB;
      ALUOP_AND:   alu = IdEx_OpA & IdEx_OpB;
      ALUOP_PASSB: alu = IdEx_OpB;
      default:     alu = '0;
    endcase
  end

  // Stall cycles push a bubble: control cleared, data left as is
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      ExMem_AluResult <= '0;
      ExMem_AluB_Pc4  <= '0;
      ExMem_MemToReg  <= 1'b0;
      ExMem_MemRead   <= 1'b0;
      ExMem_MemWrite  <= 1'b0;
      ExMem_RegRd     <= '0;
      ExMem_RegWrite  <= 1'b0;
    end else if (ExStall) begin
      ExMem_MemToReg  <= 1'b0;
      ExMem_MemRead   <= 1'b0;
      ExMem_MemWrite  <= 1'b0;
      ExMem_RegWrite  <= 1'b0;
    end else begin
      ExMem_AluResult <= md_done ? md_result : alu;
      ExMem_AluB_Pc4  <= IdEx_Jump ? IdEx_Pc4 : IdEx_Rs2Data;
      ExMem_RegRd     <= IdEx_RegRd;
      ExMem_MemToReg  <= IdEx_Valid && IdEx_MemToReg;
      ExMem_MemRead   <= IdEx_Valid && IdEx_MemRead;
      ExMem_MemWrite  <= IdEx_Valid && IdEx_MemWrite;
      ExMem_RegWrite  <= IdEx_Valid && IdEx_RegWrite;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed-vector bench for exe_stage: ALU ops, M-unit timing/results, bubbles, reset abort.
module tb_exe_stage;
  import exe_pkg::*;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        IdEx_Valid, IdEx_Jump, IdEx_MemToReg, IdEx_MemRead, IdEx_MemWrite, IdEx_RegWrite;
  logic [4:0]  IdEx_AluOp, IdEx_RegRd;
  logic [31:0] IdEx_OpA, IdEx_OpB, IdEx_Rs2Data, IdEx_Pc4;
  logic        ExStall, ExMem_MemToReg, ExMem_MemRead, ExMem_MemWrite, ExMem_RegWrite;
  logic [31:0] ExMem_AluResult, ExMem_AluB_Pc4;
  logic [4:0]  ExMem_RegRd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk(clk), .rstb(rstb),
    .IdEx_Valid(IdEx_Valid), .IdEx_AluOp(IdEx_AluOp), .IdEx_OpA(IdEx_OpA), .IdEx_OpB(IdEx_OpB),
    .IdEx_Rs2Data(IdEx_Rs2Data), .IdEx_Pc4(IdEx_Pc4), .IdEx_Jump(IdEx_Jump),
    .IdEx_MemToReg(IdEx_MemToReg), .IdEx_MemRead(IdEx_MemRead), .IdEx_MemWrite(IdEx_MemWrite),
    .IdEx_RegRd(IdEx_RegRd), .IdEx_RegWrite(IdEx_RegWrite),
    .ExStall(ExStall), .ExMem_AluResult(ExMem_AluResult), .ExMem_AluB_Pc4(ExMem_AluB_Pc4),
    .ExMem_MemToReg(ExMem_MemToReg), .ExMem_MemRead(ExMem_MemRead), .ExMem_MemWrite(ExMem_MemWrite),
    .ExMem_RegRd(ExMem_RegRd), .ExMem_RegWrite(ExMem_RegWrite)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    IdEx_Valid = v;  IdEx_AluOp = op;  IdEx_OpA = a;  IdEx_OpB = b;
    IdEx_Rs2Data = '0;  IdEx_Pc4 = '0;  IdEx_Jump = 1'b0;
    IdEx_MemToReg = 1'b0;  IdEx_MemRead = 1'b0;  IdEx_MemWrite = 1'b0;
    IdEx_RegRd = 5'd5;  IdEx_RegWrite = 1'b1;
  endtask

  // Called 1 time unit after a posedge; leaves 1 time unit after the next one
  task automatic alu_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    drv(1'b1, op, a, b);
    #1 chk({tag, "_stall"}, {31'b0, ExStall}, 32'd0);
    @(posedge clk); #1;
    chk(tag, ExMem_AluResult, exp);
  endtask

  task automatic md_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_stalls);
    int n = 0;
    logic rw_bad = 1'b0;
    drv(1'b1, op, a, b);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!ExStall) break;
      n++;
      if (n >= 2 && ExMem_RegWrite) rw_bad = 1'b1;
    end
    chk({tag, "_stalls"}, n, exp_stalls);
    chk({tag, "_bubble_rw"}, {31'b0, rw_bad}, 32'd0);
    @(posedge clk); #1;
    chk(tag, ExMem_AluResult, exp);
    chk({tag, "_rw"}, {31'b0, ExMem_RegWrite}, 32'd1);
  endtask

  initial begin
    drv(1'b0, ALUOP_ADD, '0, '0);
    #1;
    chk("rst_result", ExMem_AluResult, 32'd0);
    chk("rst_rw", {31'b0, ExMem_RegWrite}, 32'd0);
    chk("rst_stall", {31'b0, ExStall}, 32'd0);
    #11 rstb = 1'b1;
    @(posedge clk); #1;

    alu_op("add_ovf", ALUOP_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
    chk("add_rw", {31'b0, ExMem_RegWrite}, 32'd1);
    chk("add_rd", {27'b0, ExMem_RegRd}, 32'd5);
    alu_op("sra", ALUOP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
    alu_op("srl", ALUOP_SRL, 32'h8000_0000, 32'h24, 32'h0800_0000);
    alu_op("sub", ALUOP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_op("slt", ALUOP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_op("sltu", ALUOP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);

    // Store: AluB carries store data
    drv(1'b1, ALUOP_ADD, 32'h100, 32'd8);
    IdEx_Rs2Data = 32'hDEAD_BEEF;  IdEx_Pc4 = 32'h55;  IdEx_MemWrite = 1'b1;  IdEx_RegWrite = 1'b0;
    @(posedge clk); #1;
    chk("st_addr", ExMem_AluResult, 32'h108);
    chk("st_data", ExMem_AluB_Pc4, 32'hDEAD_BEEF);
    chk("st_mw", {31'b0, ExMem_MemWrite}, 32'd1);

    // JAL: AluB carries Pc4
    drv(1'b1, ALUOP_ADD, 32'h100, 32'd20);
    IdEx_Jump = 1'b1;  IdEx_Pc4 = 32'h104;  IdEx_Rs2Data = 32'h1234;
    @(posedge clk); #1;
    chk("jal_pc4", ExMem_AluB_Pc4, 32'h104);

    // Invalid: control cleared, data still loads
    drv(1'b0, ALUOP_ADD, 32'd3, 32'd4);
    IdEx_MemToReg = 1'b1;  IdEx_MemRead = 1'b1;  IdEx_MemWrite = 1'b1;
    @(posedge clk); #1;
    chk("inv_ctrl", {28'b0, ExMem_RegWrite, ExMem_MemRead, ExMem_MemWrite, ExMem_MemToReg}, 32'd0);
    chk("inv_data", ExMem_AluResult, 32'd7);

    md_op("mul",    ALUOP_MUL,    32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFA, 33);
    md_op("mulh",   ALUOP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    md_op("mulhu",  ALUOP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    md_op("mulhsu", ALUOP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    md_op("div0",   ALUOP_DIV,    32'd7,         32'd0,         32'hFFFF_FFFF, 1);
    md_op("rem0",   ALUOP_REM,    32'd7,         32'd0,         32'd7,         1);
    md_op("divovf", ALUOP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    md_op("removf", ALUOP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
    md_op("rem_neg", ALUOP_REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
    md_op("div_neg", ALUOP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
    md_op("divu",   ALUOP_DIVU,   32'd100,       32'd7,         32'd14,        33);

    // Reset in the middle of a divide
    drv(1'b1, ALUOP_DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2 rstb = 1'b0;
    IdEx_Valid = 1'b0;
    #1;
    chk("abort_stall", {31'b0, ExStall}, 32'd0);
    chk("abort_result", ExMem_AluResult, 32'd0);
    chk("abort_rw", {31'b0, ExMem_RegWrite}, 32'd0);
    @(negedge clk) rstb = 1'b1;
    @(posedge clk); #1;
    md_op("divu_after", ALUOP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage RV32IM pipeline. It consumes the ID/EX register contents and produces the ExMem_* register set consumed by the memory stage.
- Single-cycle RV32I ALU ops complete in one cycle.
- RV32M ops run on an iterative radix-2 multiply/divide unit. While that unit is busy, the block asserts ExStall to freeze IF/ID/EX and inserts bubbles into EX/MEM.

Parameters:
XLEN, 32, datapath width (only 32 supported)
MD_ITER, 32, iteration count of the multiply/divide unit (must equal XLEN)

Ports:
clk  input  1  clock
rstb  input  1  reset, asynchronous, active-low
IdEx_Valid  input  1  ID/EX holds a real instruction
IdEx_AluOp  input  5  operation code (pkg encoding)
IdEx_OpA  input  32  operand A (rs1 or PC, already forwarded)
IdEx_OpB  input  32  operand B (rs2 or immediate, already forwarded)
IdEx_Rs2Data  input  32  store data
IdEx_Pc4  input  32  PC+4 of the instruction
IdEx_Jump  input  1  JAL/JALR: AluB_Pc4 carries Pc4
IdEx_MemToReg  input  1  load writes back memory data
IdEx_MemRead  input  1  load
IdEx_MemWrite  input  1  store
IdEx_RegRd  input  5  destination register
IdEx_RegWrite  input  1  writes register file
ExStall  output  1  hold upstream stages and PC (combinational)
ExMem_AluResult  output  32  ALU or M-unit result / memory address
ExMem_AluB_Pc4  output  32  store data or PC+4
ExMem_MemToReg  output  1  registered IdEx_MemToReg
ExMem_MemRead  output  1  registered IdEx_MemRead
ExMem_MemWrite  output  1  registered IdEx_MemWrite
ExMem_RegRd  output  5  registered IdEx_RegRd
ExMem_RegWrite  output  1  registered IdEx_RegWrite

Behaviour:
- Reset: all ExMem_* outputs are 0, the FSM is IDLE, the counter is 0, and ExStall is 0. Reset asserted mid-division aborts the operation immediately, with no result and no stall.
- ALU ops (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB):
  - Result is registered into ExMem at the next clk edge, giving latency 1 and ExStall 0.
  - Shift amount is OpB[4:0]. SLT and SLTU produce 0 or 1, zero-extended.
- ExMem_AluB_Pc4 = IdEx_Jump ? IdEx_Pc4 : IdEx_Rs2Data.
- IdEx_Valid=0:
  - ExMem_RegWrite, ExMem_MemRead, ExMem_MemWrite and ExMem_MemToReg load 0.
  - Data fields load normally.
  - The M-unit is not started.
- M-unit FSM, with states IDLE, CALC and DONE:
  - IDLE:
    - A valid M op, with operands not special, goes to CALC. The FSM latches operand magnitudes and sign flags, and sets cnt=0.
    - A special case goes straight to DONE.
    - ExStall=1 in the cycle a valid M op is present.
  - CALC: one shift-add or shift-subtract step per cycle. The FSM goes to DONE when cnt=MD_ITER-1. ExStall=1.
  - DONE:
    - The result is sign-corrected (two's-complement negate where required).
    - ExStall=0, so ExMem captures the result and the upstream pipeline advances.
    - Next state is IDLE.
- M-unit timing:
  - For a full M op presented in cycle t, ExStall is high in cycles t..t+32 (33 cycles) and DONE is cycle t+33. The result is visible on ExMem_AluResult from cycle t+34.
  - For a special case, ExStall is high in cycle t only and the result is visible at t+2.
- While ExStall=1:
  - ExMem loads a bubble: control bits 0, data unchanged.
  - IdEx_* inputs are held stable by upstream. The block does not relatch them after the IDLE start.
- MUL returns the low 32 bits of the 64-bit product.
- MULH, MULHSU and MULHU return the high 32 bits with signed×signed, signed×unsigned and unsigned×unsigned operands respectively. Sign is applied to the 64-bit product before the high half is selected.
- Special cases, resolved without iteration:
  - DIV or DIVU by 0 gives 0xFFFFFFFF.
  - REM or REMU by 0 gives OpA.
  - DIV of 0x80000000 by 0xFFFFFFFF gives 0x80000000.
  - REM of 0x80000000 by 0xFFFFFFFF gives 0.
- REM takes the sign of the dividend; DIV truncates toward zero.
- Back-to-back M ops: after DONE the FSM returns to IDLE. The next M op, presented in the following cycle, starts a new sequence with no extra dead cycle.

Decomposition:
- Package exe_pkg contains:
  - localparam ALUOP_* codes, 5 bits: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10, MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23.
  - An is_mdu(op) function, true when op[4]=1.
  - The MD state encoding.
- One sub-module, muldiv_iter, contains the FSM, counter, shift registers, sign fix and special-case detection. Its interface is start, op, a, b, busy, done and result.
- The ALU and EX/MEM register stay in exe_stage.

Test Plan:
- ADD with OpA=0x7FFFFFFF and OpB=1 -> ExMem_AluResult=0x80000000 the next cycle, ExStall=0. SRA with OpA=0x80000000 and OpB=4 -> 0xF8000000.
- MUL with OpA=0xFFFFFFFE (-2) and OpB=3 -> ExStall high for 33 cycles, then ExMem_AluResult=0xFFFFFFFA with ExMem_RegWrite=1. ExMem_RegWrite=0 during the stall.
- MULH with OpA=0x80000000 and OpB=0x80000000 -> 0x40000000. MULHU with 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU with 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 7/0 -> 0xFFFFFFFF and REM 7/0 -> 7, each with 1 stall cycle. DIV 0x80000000/-1 -> 0x80000000. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14.
- Store with Rs2Data=0xDEADBEEF -> ExMem_AluB_Pc4=0xDEADBEEF. JAL with Pc4=0x104 -> ExMem_AluB_Pc4=0x104. IdEx_Valid=0 -> all ExMem control bits 0.
- rstb pulsed low at cycle 10 of a DIVU -> outputs 0 and ExStall=0 immediately. A fresh DIVU 9/3 afterwards -> 3 with full 33-cycle stall.
